// File: rtl/cle_area_stat.sv
// rtl/cle_area_stat.sv - per-label area accumulation over a 32x32 label map
// Clears the stat RAM, scans the label map in runs, and adds each run's length to stat[label].
module cle_area_stat #(
    parameter int ADDR_W = 10,
    parameter int LBL_W  = 8,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] sram_a,
    input  logic [LBL_W-1:0]  sram_q,
    output logic [LBL_W-1:0]  stat_a,
    input  logic [CNT_W-1:0]  stat_q,
    output logic [CNT_W-1:0]  stat_d,
    output logic              stat_wen,
    output logic              busy,
    output logic [LBL_W-1:0]  obj_cnt,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RD_PIX,
        S_CHK,
        S_FL_RD,
        S_FL_WR,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] P_LAST   = '1;
    localparam logic [LBL_W-1:0]  CLR_LAST = '1;

    state_t            state_q;
    logic [LBL_W-1:0]  clr_q;
    logic [ADDR_W-1:0] p_q;
    logic [ADDR_W-1:0] sram_a_q;
    logic [LBL_W-1:0]  run_label_q;
    logic [CNT_W-1:0]  run_len_q;
    logic [LBL_W-1:0]  pend_q;
    logic              end_q;
    logic [LBL_W-1:0]  obj_cnt_q;
    logic              done_q;

    // Sum for the flush write; stat_q carries stat[run_label] during FL_WR.
    logic [CNT_W-1:0]  flush_sum_d;
    assign flush_sum_d = stat_q + run_len_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clr_q       <= '0;
            p_q         <= '0;
            sram_a_q    <= '0;
            run_label_q <= '0;
            run_len_q   <= '0;
            pend_q      <= '0;
            end_q       <= 1'b0;
            obj_cnt_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        clr_q       <= LBL_W'(1);
                        obj_cnt_q   <= '0;
                        done_q      <= 1'b0;
                        run_label_q <= '0;
                        run_len_q   <= '0;
                        p_q         <= '0;
                        end_q       <= 1'b0;
                        state_q     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    clr_q <= clr_q + LBL_W'(1);
                    if (clr_q == CLR_LAST) begin
                        state_q <= S_RD_PIX;
                    end
                end
                S_RD_PIX: begin
                    sram_a_q <= p_q;
                    state_q  <= S_CHK;
                end
                S_CHK: begin
                    if (sram_q == run_label_q || run_label_q == '0) begin
                        if (sram_q == run_label_q) begin
                            run_len_q <= run_len_q + CNT_W'(sram_q != '0);
                        end else begin
                            run_label_q <= sram_q;
                            run_len_q   <= CNT_W'(1);
                        end
                        if (p_q == P_LAST) begin
                            end_q <= 1'b1;
                            if (sram_q != '0) begin
                                state_q <= S_FL_RD;
                            end else begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            p_q     <= p_q + ADDR_W'(1);
                            state_q <= S_RD_PIX;
                        end
                    end else begin
                        // Pixel p starts a new run; it is consumed once the old run is flushed.
                        pend_q  <= sram_q;
                        end_q   <= 1'b0;
                        state_q <= S_FL_RD;
                    end
                end
                S_FL_RD: begin
                    state_q <= S_FL_WR;
                end
                S_FL_WR: begin
                    if (stat_q == '0) begin
                        obj_cnt_q <= obj_cnt_q + LBL_W'(1);
                    end
                    if (end_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        run_label_q <= pend_q;
                        run_len_q   <= CNT_W'(pend_q != '0);
                        if (p_q == P_LAST) begin
                            end_q <= 1'b1;
                            if (pend_q != '0) begin
                                state_q <= S_FL_RD;
                            end else begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            p_q     <= p_q + ADDR_W'(1);
                            state_q <= S_RD_PIX;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy     = !(state_q == S_IDLE || state_q == S_DONE);
        sram_a   = (state_q == S_RD_PIX) ? p_q : sram_a_q;
        stat_a   = run_label_q;
        stat_d   = '0;
        stat_wen = 1'b1;
        case (state_q)
            S_CLEAR: begin
                stat_a   = clr_q;
                stat_wen = 1'b0;
            end
            S_FL_WR: begin
                stat_d   = flush_sum_d;
                stat_wen = 1'b0;
            end
            default: begin
                stat_wen = 1'b1;
            end
        endcase
    end

    assign obj_cnt = obj_cnt_q;
    assign done    = done_q;

endmodule
